// File: rtl/alu_muldiv_seq.sv
// EX-stage ALU with registered outputs, a sequential shift-add multiplier,
// a restoring divider and architectural HI/LO registers.
// Single-cycle ops complete on the accept edge. Mult/div load on the accept
// edge, iterate once per cycle and enter DONE on their final iteration edge.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2, ST_DONE = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
    OP_XOR = 4'd4, OP_NOR = 4'd5, OP_SLT = 4'd6, OP_SLTU = 4'd7,
    OP_MFHI = 4'd8, OP_MFLO = 4'd9, OP_MULT = 4'd10, OP_MULTU = 4'd11,
    OP_DIV = 4'd12, OP_DIVU = 4'd13, OP_ILL = 4'd14
  } op_t;

  state_t                state_r, state_next_s;
  op_t                   op_s;
  logic [CW-1:0]         cnt_r;
  logic [2*WIDTH:0]      acc_r;        // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]      opnd_r;       // multiplicand or divisor magnitude
  logic                  neg_lo_r, neg_hi_r;
  logic [WIDTH-1:0]      result_r, hi_r, lo_r;
  logic                  zero_r, done_r, dbz_r, ill_r;
  logic                  sgn_s, b_zero_s;
  logic [WIDTH-1:0]      alu_res_s;
  logic [WIDTH:0]        mul_upper_s, div_shift_s, div_trial_s;
  logic [2*WIDTH:0]      mul_step_s, div_step_s;
  logic [2*WIDTH-1:0]    fin_prod_s;
  logic [WIDTH-1:0]      fin_quo_s, fin_rem_s;

  // Two's-complement magnitude of a signed operand; unsigned operands pass through.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      magnitude = -v;
    end else begin
      magnitude = v;
    end
  endfunction

  // Decode aluop/funct into an internal operation code.
  always_comb begin
    op_s = OP_ILL;
    case (aluop)
      2'b00: op_s = OP_ADD;
      2'b01: op_s = OP_SUB;
      2'b10: begin
        case (funct)
          6'b100000: op_s = OP_ADD;
          6'b100010: op_s = OP_SUB;
          6'b100100: op_s = OP_AND;
          6'b100101: op_s = OP_OR;
          6'b100110: op_s = OP_XOR;
          6'b100111: op_s = OP_NOR;
          6'b101010: op_s = OP_SLT;
          6'b101011: op_s = OP_SLTU;
          6'b010000: op_s = OP_MFHI;
          6'b010010: op_s = OP_MFLO;
          6'b011000: op_s = OP_MULT;
          6'b011001: op_s = OP_MULTU;
          6'b011010: op_s = OP_DIV;
          6'b011011: op_s = OP_DIVU;
          default:   op_s = OP_ILL;
        endcase
      end
      default: op_s = OP_ILL;
    endcase
  end

  // Single-cycle results plus one multiply and one divide iteration with sign fix-up.
  always_comb begin
    sgn_s    = (op_s == OP_MULT) || (op_s == OP_DIV);
    b_zero_s = (b == ZERO_W);
    case (op_s)
      OP_ADD:  alu_res_s = a + b;
      OP_SUB:  alu_res_s = a - b;
      OP_AND:  alu_res_s = a & b;
      OP_OR:   alu_res_s = a | b;
      OP_XOR:  alu_res_s = a ^ b;
      OP_NOR:  alu_res_s = ~(a | b);
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MFHI: alu_res_s = hi_r;
      OP_MFLO: alu_res_s = lo_r;
      default: alu_res_s = ZERO_W;
    endcase
    mul_upper_s = acc_r[2*WIDTH:WIDTH] + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    mul_step_s  = {1'b0, mul_upper_s, acc_r[WIDTH-1:1]};
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, opnd_r};
    if (!div_trial_s[WIDTH]) begin
      div_step_s = {div_trial_s, acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_step_s = {div_shift_s, acc_r[WIDTH-2:0], 1'b0};
    end
    fin_prod_s = neg_lo_r ? -mul_step_s[2*WIDTH-1:0] : mul_step_s[2*WIDTH-1:0];
    fin_quo_s  = neg_lo_r ? -div_step_s[WIDTH-1:0] : div_step_s[WIDTH-1:0];
    fin_rem_s  = neg_hi_r ? -div_step_s[2*WIDTH-1:WIDTH] : div_step_s[2*WIDTH-1:WIDTH];
  end

  // Next-state logic: accept only in IDLE, DONE always lasts one cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          case (op_s)
            OP_MULT, OP_MULTU: state_next_s = ST_MUL;
            OP_DIV, OP_DIVU:   state_next_s = b_zero_s ? ST_DONE : ST_DIV;
            default:           state_next_s = ST_DONE;
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MUL:  state_next_s = (cnt_r == CNT_LAST) ? ST_DONE : ST_MUL;
      ST_DIV:  state_next_s = (cnt_r == CNT_LAST) ? ST_DONE : ST_DIV;
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: operand capture, iteration, and result/HI/LO/flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*WIDTH+1){1'b0}};
      opnd_r   <= ZERO_W;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
      result_r <= ZERO_W;
      hi_r     <= ZERO_W;
      lo_r     <= ZERO_W;
      zero_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
      ill_r    <= 1'b0;
    end else begin
      done_r <= (state_next_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            cnt_r  <= {CW{1'b0}};
            dbz_r  <= 1'b0;
            ill_r  <= 1'b0;
            zero_r <= 1'b0;
            case (op_s)
              OP_MULT, OP_MULTU: begin
                acc_r    <= {{(WIDTH+1){1'b0}}, magnitude(b, sgn_s)};
                opnd_r   <= magnitude(a, sgn_s);
                neg_lo_r <= sgn_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_hi_r <= sgn_s && (a[WIDTH-1] ^ b[WIDTH-1]);
              end
              OP_DIV, OP_DIVU: begin
                if (b_zero_s) begin
                  lo_r     <= ONES_W;
                  hi_r     <= a;
                  result_r <= ONES_W;
                  dbz_r    <= 1'b1;
                end else begin
                  acc_r    <= {{(WIDTH+1){1'b0}}, magnitude(a, sgn_s)};
                  opnd_r   <= magnitude(b, sgn_s);
                  neg_lo_r <= sgn_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_hi_r <= sgn_s && a[WIDTH-1];
                end
              end
              OP_ILL: begin
                result_r <= ZERO_W;
                zero_r   <= 1'b1;
                ill_r    <= 1'b1;
              end
              default: begin
                result_r <= alu_res_s;
                zero_r   <= (alu_res_s == ZERO_W);
              end
            endcase
          end
        end
        ST_MUL: begin
          acc_r <= mul_step_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            {hi_r, lo_r} <= fin_prod_s;
            result_r     <= fin_prod_s[WIDTH-1:0];
            zero_r       <= (fin_prod_s[WIDTH-1:0] == ZERO_W);
          end
        end
        ST_DIV: begin
          acc_r <= div_step_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            lo_r     <= fin_quo_s;
            hi_r     <= fin_rem_s;
            result_r <= fin_quo_s;
            zero_r   <= (fin_quo_s == ZERO_W);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready       = (state_r == ST_IDLE);
  assign done        = done_r;
  assign result      = result_r;
  assign zero        = zero_r;
  assign hi          = hi_r;
  assign lo          = lo_r;
  assign div_by_zero = dbz_r;
  assign illegal     = ill_r;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed table, random ops against
// a wide-arithmetic reference model, reset abort, and an 8-bit instance.
module tb_alu_muldiv_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic start32, start8;
  logic [1:0] aluop32, aluop8;
  logic [5:0] funct32, funct8;
  logic [31:0] a32, b32;
  logic [7:0] a8, b8;
  logic ready32, done32, zero32, dbz32, ill32;
  logic [31:0] result32, hi32, lo32;
  logic ready8, done8, zero8, dbz8, ill8;
  logic [7:0] result8, hi8, lo8;

  alu_muldiv_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .aluop(aluop32), .funct(funct32),
    .a(a32), .b(b32), .ready(ready32), .done(done32), .result(result32), .zero(zero32),
    .hi(hi32), .lo(lo32), .div_by_zero(dbz32), .illegal(ill32));

  alu_muldiv_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .aluop(aluop8), .funct(funct8),
    .a(a8), .b(b8), .ready(ready8), .done(done8), .result(result8), .zero(zero8),
    .hi(hi8), .lo(lo8), .div_by_zero(dbz8), .illegal(ill8));

  int errors = 0;
  int checks = 0;

  // reference architectural state and expectations
  logic [31:0] hi_m, lo_m;
  logic [31:0] e_res, e_hi, e_lo;
  logic e_zero, e_dbz, e_ill;
  int e_lat;
  // captured DUT observations
  logic [31:0] c_res, c_hi, c_lo;
  logic c_zero, c_dbz, c_ill, c_hs;
  int c_lat;
  logic [7:0] c8_res, c8_hi, c8_lo;
  logic c8_zero;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] x;
    logic [31:0] y;
    logic        hold;
  } vec_t;
  vec_t tbl[$];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: architectural behaviour using plain wide arithmetic.
  task automatic model32(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p, qv, rv;
    longint q, r;
    e_dbz = 1'b0; e_ill = 1'b0; e_lat = 1; e_res = 32'd0;
    if (op == 2'b00) e_res = x + y;
    else if (op == 2'b01) e_res = x - y;
    else if (op == 2'b11) e_ill = 1'b1;
    else begin
      case (fn)
        6'h20: e_res = x + y;
        6'h22: e_res = x - y;
        6'h24: e_res = x & y;
        6'h25: e_res = x | y;
        6'h26: e_res = x ^ y;
        6'h27: e_res = ~(x | y);
        6'h2A: e_res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        6'h2B: e_res = (x < y) ? 32'd1 : 32'd0;
        6'h10: e_res = hi_m;
        6'h12: e_res = lo_m;
        6'h18, 6'h19: begin
          if (fn == 6'h18) p = longint'($signed(x)) * longint'($signed(y));
          else p = {32'd0, x} * {32'd0, y};
          hi_m = p[63:32]; lo_m = p[31:0]; e_res = lo_m; e_lat = 33;
        end
        6'h1A, 6'h1B: begin
          if (y == 32'd0) begin
            hi_m = x; lo_m = 32'hFFFF_FFFF; e_dbz = 1'b1;
          end else begin
            if (fn == 6'h1A) begin
              q = longint'($signed(x)) / longint'($signed(y));
              r = longint'($signed(x)) % longint'($signed(y));
            end else begin
              q = longint'({32'd0, x}) / longint'({32'd0, y});
              r = longint'({32'd0, x}) % longint'({32'd0, y});
            end
            qv = q; rv = r;
            lo_m = qv[31:0]; hi_m = rv[31:0]; e_lat = 33;
          end
          e_res = lo_m;
        end
        default: e_ill = 1'b1;
      endcase
    end
    e_zero = (e_res == 32'd0);
    e_hi = hi_m;
    e_lo = lo_m;
  endtask

  // Issue one op on the 32-bit DUT and capture outputs at the done pulse.
  task automatic run32(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y, input logic hold);
    @(negedge clk);
    aluop32 = op; funct32 = fn; a32 = x; b32 = y; start32 = 1'b1;
    @(posedge clk); #1;
    c_hs = ~ready32;
    if (!hold) start32 = 1'b0;
    c_lat = 1;
    while (!done32 && c_lat < 200) begin
      @(posedge clk); #1;
      c_lat++;
    end
    start32 = 1'b0;
    c_res = result32; c_hi = hi32; c_lo = lo32;
    c_zero = zero32; c_dbz = dbz32; c_ill = ill32;
    @(posedge clk); #1;
    c_hs = c_hs & ~done32 & ready32;
  endtask

  // Issue one op on the 8-bit DUT.
  task automatic run8(input logic [1:0] op, input logic [5:0] fn, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    aluop8 = op; funct8 = fn; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    c_lat = 1;
    while (!done8 && c_lat < 200) begin
      @(posedge clk); #1;
      c_lat++;
    end
    c8_res = result8; c8_hi = hi8; c8_lo = lo8; c8_zero = zero8;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rx, ry;
    reset_n = 1'b0; start32 = 1'b0; start8 = 1'b0;
    aluop32 = 2'b00; funct32 = 6'h00; a32 = 32'd0; b32 = 32'd0;
    aluop8 = 2'b00; funct8 = 6'h00; a8 = 8'd0; b8 = 8'd0;
    hi_m = 32'd0; lo_m = 32'd0;
    #12;
    checks++;
    if ({result32, hi32, lo32, zero32, done32, dbz32, ill32, ready32} !== {96'd0, 5'b00001}) begin
      errors++; $display("FAIL reset_state: got %h/%h/%h flags %b ready %b want all zero, ready 1",
                         result32, hi32, lo32, {zero32, done32, dbz32, ill32}, ready32);
    end
    @(negedge clk); reset_n = 1'b1;
    // load HI/LO with something nonzero first
    model32(2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run32(2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (c_hi !== e_hi || c_lo !== e_lo) begin
      errors++; $display("FAIL reset_preload: got hi %h lo %h want hi %h lo %h", c_hi, c_lo, e_hi, e_lo);
    end
    rx = $urandom; ry = $urandom;
    @(negedge clk);
    aluop32 = 2'b10; funct32 = 6'h18; a32 = rx; b32 = ry; start32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0;
    repeat (5) @(posedge clk);
    #2; reset_n = 1'b0; #1;
    checks++;
    if ({result32, hi32, lo32, zero32, done32, dbz32, ill32, ready32} !== {96'd0, 5'b00001}) begin
      errors++; $display("FAIL reset_mid_mul: got %h/%h/%h flags %b ready %b want all zero, ready 1",
                         result32, hi32, lo32, {zero32, done32, dbz32, ill32}, ready32);
    end
    hi_m = 32'd0; lo_m = 32'd0;
    @(negedge clk); reset_n = 1'b1;
    model32(2'b10, 6'h10, 32'd0, 32'd0);
    run32(2'b10, 6'h10, 32'd0, 32'd0, 1'b0);
    checks++;
    if (c_res !== 32'd0) begin
      errors++; $display("FAIL reset_mfhi: got %h want %h", c_res, 32'd0);
    end
  endtask

  task automatic test_table();
    tbl.push_back('{2'b00, 6'h00, 32'd7, 32'd5, 1'b0});
    tbl.push_back('{2'b01, 6'h00, 32'd5, 32'd7, 1'b0});
    tbl.push_back('{2'b10, 6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0});
    tbl.push_back('{2'b10, 6'h25, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0});
    tbl.push_back('{2'b10, 6'h26, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0});
    tbl.push_back('{2'b10, 6'h27, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0});
    tbl.push_back('{2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 1'b0});
    tbl.push_back('{2'b10, 6'h2B, 32'hFFFF_FFFF, 32'd1, 1'b0});
    tbl.push_back('{2'b01, 6'h00, 32'd3, 32'd3, 1'b0});
    tbl.push_back('{2'b10, 6'h22, 32'd10, 32'd4, 1'b0});
    tbl.push_back('{2'b10, 6'h18, 32'hFFFF_FFFD, 32'd5, 1'b1});
    tbl.push_back('{2'b10, 6'h12, 32'd0, 32'd0, 1'b0});
    tbl.push_back('{2'b10, 6'h10, 32'd0, 32'd0, 1'b0});
    tbl.push_back('{2'b10, 6'h19, 32'hFFFF_FFFF, 32'd2, 1'b0});
    tbl.push_back('{2'b10, 6'h1A, 32'hFFFF_FFF9, 32'd2, 1'b0});
    tbl.push_back('{2'b10, 6'h1B, 32'd100, 32'd7, 1'b0});
    tbl.push_back('{2'b10, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{2'b10, 6'h1A, 32'd9, 32'd0, 1'b0});
    tbl.push_back('{2'b11, 6'h20, 32'd1, 32'd2, 1'b0});
    tbl.push_back('{2'b10, 6'h3F, 32'd1, 32'd2, 1'b0});
    tbl.push_back('{2'b10, 6'h10, 32'd0, 32'd0, 1'b0});
    foreach (tbl[i]) begin
      model32(tbl[i].op, tbl[i].fn, tbl[i].x, tbl[i].y);
      run32(tbl[i].op, tbl[i].fn, tbl[i].x, tbl[i].y, tbl[i].hold);
      checks++;
      if (c_res !== e_res) begin errors++; $display("FAIL tbl%0d result: got %h want %h", i, c_res, e_res); end
      checks++;
      if (c_hi !== e_hi) begin errors++; $display("FAIL tbl%0d hi: got %h want %h", i, c_hi, e_hi); end
      checks++;
      if (c_lo !== e_lo) begin errors++; $display("FAIL tbl%0d lo: got %h want %h", i, c_lo, e_lo); end
      checks++;
      if ({c_zero, c_dbz, c_ill} !== {e_zero, e_dbz, e_ill}) begin
        errors++; $display("FAIL tbl%0d flags(z,dbz,ill): got %b want %b", i, {c_zero, c_dbz, c_ill}, {e_zero, e_dbz, e_ill});
      end
      checks++;
      if (c_lat !== e_lat) begin errors++; $display("FAIL tbl%0d latency: got %0d want %0d", i, c_lat, e_lat); end
      checks++;
      if (c_hs !== 1'b1) begin errors++; $display("FAIL tbl%0d handshake: got %b want 1", i, c_hs); end
    end
  endtask

  task automatic test_random();
    logic [5:0] codes[16];
    logic [1:0] op;
    logic [5:0] fn;
    logic [31:0] x, y;
    codes = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
              6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h3F, 6'h00};
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 3) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
      fn = codes[$urandom_range(0, 15)];
      x = $urandom;
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      model32(op, fn, x, y);
      run32(op, fn, x, y, 1'b0);
      checks++;
      if (c_res !== e_res || c_hi !== e_hi || c_lo !== e_lo) begin
        errors++; $display("FAIL rnd%0d values op=%b fn=%h a=%h b=%h: got %h/%h/%h want %h/%h/%h",
                           n, op, fn, x, y, c_res, c_hi, c_lo, e_res, e_hi, e_lo);
      end
      checks++;
      if ({c_zero, c_dbz, c_ill} !== {e_zero, e_dbz, e_ill} || c_lat !== e_lat || c_hs !== 1'b1) begin
        errors++; $display("FAIL rnd%0d timing/flags: got z,dbz,ill=%b lat=%0d hs=%b want %b lat=%0d hs=1",
                           n, {c_zero, c_dbz, c_ill}, c_lat, c_hs, {e_zero, e_dbz, e_ill}, e_lat);
      end
    end
  endtask

  task automatic test_width8();
    int pi, qd, rd;
    logic [31:0] pv;
    logic [15:0] p16;
    logic [7:0] q8, r8;
    run8(2'b00, 6'h00, 8'hFF, 8'h01);
    checks++;
    if (c8_res !== 8'h00 || c8_zero !== 1'b1) begin
      errors++; $display("FAIL w8_add: got %h zero %b want 00 zero 1", c8_res, c8_zero);
    end
    checks++;
    if (c_lat !== 1) begin errors++; $display("FAIL w8_add_latency: got %0d want 1", c_lat); end
    pi = -3 * 5; pv = pi; p16 = pv[15:0];
    run8(2'b10, 6'h18, 8'hFD, 8'h05);
    checks++;
    if ({c8_hi, c8_lo} !== p16 || c8_res !== p16[7:0]) begin
      errors++; $display("FAIL w8_mult: got hi %h lo %h res %h want %h", c8_hi, c8_lo, c8_res, p16);
    end
    checks++;
    if (c_lat !== 9) begin errors++; $display("FAIL w8_mult_latency: got %0d want 9", c_lat); end
    qd = 200 / 7; rd = 200 % 7; q8 = 8'(qd); r8 = 8'(rd);
    run8(2'b10, 6'h1B, 8'd200, 8'd7);
    checks++;
    if (c8_lo !== q8 || c8_hi !== r8 || c_lat !== 9) begin
      errors++; $display("FAIL w8_divu: got lo %h hi %h lat %0d want lo %h hi %h lat 9", c8_lo, c8_hi, c_lat, q8, r8);
    end
  endtask

  initial begin
    test_reset();
    test_table();
    test_random();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
